// File: rtl/csa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csa_pkg : shared types and sizing for the carry-save resolver datapath    |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
package csa_pkg;

  localparam int CSA_WIDTH = 17;
  localparam int CSA_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } resolver_state_t;

  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpa_chunk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpa_chunk : combinational CHUNK-bit ripple adder built from full adders   |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module cpa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  logic [CHUNK:0] w_carry;

  assign w_carry[0] = cin;

  generate
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (w_carry[i]),
        .s  (s[i]),
        .co (w_carry[i+1])
      );
    end
  endgenerate

  assign cout = w_carry[CHUNK];
endmodule
`default_nettype wire

// File: rtl/csa_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csa_resolver : digit-serial carry-propagate resolver for carry-save pairs |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module csa_resolver
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int CHUNK = CSA_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] vs,
  input  logic [WIDTH-1:0] vc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);
  localparam int NCHUNK       = nchunk(WIDTH, CHUNK);
  localparam int PW           = NCHUNK * CHUNK;
  localparam int IDXW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int MSB_IN_CHUNK = (WIDTH - 1) % CHUNK;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  resolver_state_t  state_q, state_d;
  logic [WIDTH-1:0] vs_op_q, vs_op_d;
  logic [WIDTH-1:0] vc_op_q, vc_op_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [PW-1:0]    w_vs_pad, w_vc_pad;
  logic [CHUNK-1:0] w_vs_chunks [NCHUNK];
  logic [CHUNK-1:0] w_vc_chunks [NCHUNK];
  logic [CHUNK-1:0] w_chunk_a, w_chunk_b, w_chunk_s;
  logic             w_chunk_cout;
  logic [WIDTH-1:0] w_sum_wr;

  // Zero-extend the operands so a partial top chunk reads zeros above the MSB.
  generate
    for (genvar b = 0; b < PW; b++) begin : g_pad
      if (b < WIDTH) begin : g_op
        assign w_vs_pad[b] = vs_op_q[b];
        assign w_vc_pad[b] = vc_op_q[b];
      end else begin : g_zero
        assign w_vs_pad[b] = 1'b0;
        assign w_vc_pad[b] = 1'b0;
      end
    end

    for (genvar c = 0; c < NCHUNK; c++) begin : g_slice
      assign w_vs_chunks[c] = w_vs_pad[c*CHUNK +: CHUNK];
      assign w_vc_chunks[c] = w_vc_pad[c*CHUNK +: CHUNK];
    end

    // Only the chunk selected by idx is overwritten; bits above WIDTH-1 are dropped.
    for (genvar b = 0; b < WIDTH; b++) begin : g_wr
      assign w_sum_wr[b] = (idx_q == IDXW'(b / CHUNK)) ? w_chunk_s[b % CHUNK] : sum_q[b];
    end
  endgenerate

  assign w_chunk_a = w_vs_chunks[idx_q];
  assign w_chunk_b = w_vc_chunks[idx_q];

  cpa_chunk #(
    .CHUNK (CHUNK)
  ) u_cpa_chunk (
    .a    (w_chunk_a),
    .b    (w_chunk_b),
    .cin  (carry_q),
    .s    (w_chunk_s),
    .cout (w_chunk_cout)
  );

  always_comb begin
    state_d     = state_q;
    vs_op_d     = vs_op_q;
    vc_op_d     = vc_op_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vs_op_d    = vs;
          vc_op_d    = vc;
          carry_d    = 1'b0;
          idx_d      = '0;
          sum_d      = '0;
          overflow_d = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d   = w_sum_wr;
        carry_d = w_chunk_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          // Sign of the result comes straight from the chunk adder on the final step.
          overflow_d  = (vs_op_q[WIDTH-1] == vc_op_q[WIDTH-1]) &&
                        (w_chunk_s[MSB_IN_CHUNK] != vs_op_q[WIDTH-1]);
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vs_op_q     <= '0;
      vc_op_q     <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_op_q     <= vs_op_d;
      vc_op_q     <= vc_op_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire
